// File: rtl/cpu_player_pkg.sv
// Shared types and constants for the CPU tug-of-war opponent.
package cpu_player_pkg;

    localparam int RND_W     = 9;
    localparam int COUNT_MAX = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_PRESS,
        ST_COOLDOWN
    } cpu_state_t;

endpackage

// File: rtl/cpu_player.sv
// CPU opponent: compares the LFSR value to a difficulty threshold and issues
// spaced one-cycle press pulses, counting presses and flagging LFSR lock-up.
module cpu_player
    import cpu_player_pkg::*;
#(
    parameter int WIDTH    = RND_W,
    parameter int COOLDOWN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] rnd,
    input  logic [WIDTH-1:0] difficulty,
    output logic             press,
    output logic [7:0]       press_count,
    output logic             lfsr_fault
);

    localparam logic [7:0] CD_LOAD = 8'(COOLDOWN - 1);

    cpu_state_t state, next_state;
    logic [7:0] cd_cnt;
    logic       rnd_zero;
    logic       hit;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'(COUNT_MAX)) ? v : v + 8'd1;
    endfunction

    // An all-zero LFSR value never qualifies for a press, whatever the threshold.
    assign rnd_zero = (rnd == '0);
    assign hit      = !rnd_zero && (rnd < difficulty);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (enable) next_state = ST_ARMED;
            end
            ST_ARMED: begin
                if (!enable)       next_state = ST_IDLE;
                else if (rnd_zero) next_state = ST_ARMED;
                else if (hit)      next_state = ST_PRESS;
            end
            ST_PRESS: begin
                next_state = enable ? ST_COOLDOWN : ST_IDLE;
            end
            ST_COOLDOWN: begin
                if (!enable)            next_state = ST_IDLE;
                else if (cd_cnt == 8'd0) next_state = ST_ARMED;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cd_cnt <= 8'd0;
        end else if (state == ST_PRESS) begin
            cd_cnt <= enable ? CD_LOAD : 8'd0;
        end else if (state == ST_COOLDOWN) begin
            if (!enable)             cd_cnt <= 8'd0;
            else if (cd_cnt != 8'd0) cd_cnt <= cd_cnt - 8'd1;
        end
    end

    // Count on entry to PRESS so the pulse and its count are never split by a reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_count <= 8'd0;
        end else if (state == ST_ARMED && next_state == ST_PRESS) begin
            press_count <= sat_inc(press_count);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_fault <= 1'b0;
        end else if (state == ST_ARMED && enable && rnd_zero) begin
            lfsr_fault <= 1'b1;
        end
    end

    assign press = (state == ST_PRESS);

endmodule

// File: tb/tb_cpu_player.sv
// Directed bench for cpu_player: per-cycle vector table plus multi-cycle sequences.
module tb_cpu_player;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [8:0] rnd;
    logic [8:0] difficulty;
    logic       press;
    logic [7:0] press_count;
    logic       lfsr_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_player #(.WIDTH(9), .COOLDOWN(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .rnd         (rnd),
        .difficulty  (difficulty),
        .press       (press),
        .press_count (press_count),
        .lfsr_fault  (lfsr_fault)
    );

    typedef struct {
        logic       en;
        logic [8:0] rnd;
        logic [8:0] diff;
        logic       press;
        logic [7:0] cnt;
        logic       fault;
    } vec_t;

    vec_t vec[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         n;
        int         times[5];
        int         cnt_at5;
        int         seen;
        logic [8:0] lf;
        bit         found;

        reset      = 1'b0;
        enable     = 1'b0;
        rnd        = 9'h000;
        difficulty = 9'h000;

        // cycle-by-cycle vectors: inputs before the edge, outputs after it
        vec[0]  = '{1'b1, 9'h0FF, 9'h100, 1'b0, 8'd0, 1'b0};
        vec[1]  = '{1'b1, 9'h100, 9'h100, 1'b0, 8'd0, 1'b0};
        vec[2]  = '{1'b1, 9'h1FF, 9'h1FF, 1'b0, 8'd0, 1'b0};
        vec[3]  = '{1'b1, 9'h001, 9'h000, 1'b0, 8'd0, 1'b0};
        vec[4]  = '{1'b1, 9'h0FF, 9'h100, 1'b1, 8'd1, 1'b0};
        vec[5]  = '{1'b0, 9'h001, 9'h1FF, 1'b0, 8'd1, 1'b0};
        vec[6]  = '{1'b1, 9'h001, 9'h1FF, 1'b0, 8'd1, 1'b0};
        vec[7]  = '{1'b1, 9'h000, 9'h1FF, 1'b0, 8'd1, 1'b1};
        vec[8]  = '{1'b1, 9'h000, 9'h1FF, 1'b0, 8'd1, 1'b1};
        vec[9]  = '{1'b1, 9'h005, 9'h1FF, 1'b1, 8'd2, 1'b1};
        vec[10] = '{1'b1, 9'h005, 9'h1FF, 1'b0, 8'd2, 1'b1};
        vec[11] = '{1'b0, 9'h005, 9'h1FF, 1'b0, 8'd2, 1'b1};
        vec[12] = '{1'b1, 9'h005, 9'h1FF, 1'b0, 8'd2, 1'b1};
        vec[13] = '{1'b1, 9'h005, 9'h1FF, 1'b1, 8'd3, 1'b1};
        vec[14] = '{1'b1, 9'h005, 9'h1FF, 1'b0, 8'd3, 1'b1};
        vec[15] = '{1'b1, 9'h005, 9'h1FF, 1'b0, 8'd3, 1'b1};
        vec[16] = '{1'b1, 9'h005, 9'h1FF, 1'b0, 8'd3, 1'b1};
        vec[17] = '{1'b1, 9'h005, 9'h1FF, 1'b0, 8'd3, 1'b1};
        vec[18] = '{1'b1, 9'h005, 9'h1FF, 1'b0, 8'd3, 1'b1};
        vec[19] = '{1'b1, 9'h005, 9'h1FF, 1'b1, 8'd4, 1'b1};

        repeat (2) step();
        check("reset_press", press, 0);
        check("reset_count", press_count, 0);
        check("reset_fault", lfsr_fault, 0);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            enable     = vec[i].en;
            rnd        = vec[i].rnd;
            difficulty = vec[i].diff;
            step();
            check($sformatf("vec%0d_press", i), press, vec[i].press);
            check($sformatf("vec%0d_count", i), press_count, vec[i].cnt);
            check($sformatf("vec%0d_fault", i), lfsr_fault, vec[i].fault);
        end

        // Reset release with enable high: first press 2 edges later, then every 6
        reset      = 1'b0;
        enable     = 1'b1;
        difficulty = 9'h1FF;
        rnd        = 9'h001;
        step();
        reset   = 1'b1;
        n       = 0;
        cnt_at5 = -1;
        for (int k = 0; k < 5; k++) times[k] = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            step();
            if (press === 1'b1 && n < 5) begin
                times[n] = cyc;
                n++;
                if (n == 5) cnt_at5 = press_count;
            end
        end
        for (int k = 0; k < 5; k++) check($sformatf("pulse%0d_cycle", k), times[k], 2 + 6 * k);
        check("count_after_5", cnt_at5, 5);

        // Zero difficulty with a free-running LFSR never presses
        reset = 1'b0;
        #1;
        reset      = 1'b1;
        difficulty = 9'h000;
        lf         = 9'h001;
        seen       = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            rnd = lf;
            step();
            if (press !== 1'b0) seen++;
            lf = {lf[7:0], lf[8] ^ lf[4]};
        end
        check("diff0_presses", seen, 0);
        check("diff0_count", press_count, 0);

        // Set the fault, then saturate the counter with the fault still held
        rnd        = 9'h000;
        difficulty = 9'h1FF;
        step();
        step();
        check("fault_set", lfsr_fault, 1);
        check("fault_no_press_count", press_count, 0);
        rnd = 9'h001;
        repeat (1900) step();
        check("count_saturated", press_count, 255);
        check("fault_sticky", lfsr_fault, 1);

        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (press === 1'b1) found = 1'b1;
        end
        check("press_found", found, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_press", press, 0);
        check("async_count", press_count, 0);
        check("async_fault", lfsr_fault, 0);
        step();
        reset = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
